cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm.sv | 171 +++++++++++++++++
 tb/tb_cache_fill_fsm.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fills one 16-byte cache block after a miss.
// The block is fetched from memory4c as eight 16-bit reads, one read per cycle.
// Returned words are written into the data array in the order they arrive.
// After the last word, the tag/valid array gets a one-cycle update strobe.
//
// Optional feature, selected with the macro CRITICAL_WORD_FIRST_EN:
//   - Defined: the fill starts at the missed word and wraps around within the block.
//   - Undefined: the fill always runs from word 0 to word 7.
module cache_fill_fsm #(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic [ADDR_W-1:0] memory_address,
    output logic              memory_enable,
    input  logic [15:0]       memory_data,
    input  logic              memory_data_valid,
    output logic              write_data_array,
    output logic [2:0]        fill_word,
    output logic [15:0]       fill_data,
    output logic              write_tag_array
);

    // Word index width; the counters get one extra bit so they can reach WORDS.
    localparam int IDX_W  = $clog2(WORDS);
    localparam int CNT_W  = IDX_W + 1;
    // Bits above the 16-byte block offset.
    localparam int BASE_W = ADDR_W - 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [BASE_W-1:0] base_hi;    // block address, bits [15:4]
    logic [CNT_W-1:0]  issue_cnt;  // reads issued so far, 0..WORDS
    logic [CNT_W-1:0]  recv_cnt;   // words received so far, 0..WORDS
    logic [IDX_W-1:0]  word_offset;

    logic              accept_miss;
    logic              issue_done;
    logic              recv_done;
    logic [IDX_W-1:0]  addr_idx;
    logic [IDX_W-1:0]  issue_word;
    logic [IDX_W-1:0]  recv_word;

`ifdef CRITICAL_WORD_FIRST_EN
    logic [IDX_W-1:0] crit_word;   // missed word; the rotation origin for this fill

    // Capture the missed word index when a miss is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crit_word <= '0;
        end else if (accept_miss) begin
            crit_word <= miss_address[3:1];
        end
    end

    assign word_offset = crit_word;
`else
    // The block offset bits are not used when every fill starts at word 0.
    logic unused_miss_offset;
    assign unused_miss_offset = ^miss_address[3:0];
    assign word_offset        = '0;
`endif

    // The MSB of a counter is set once all WORDS reads have been issued or received.
    assign issue_done = issue_cnt[CNT_W-1];
    assign recv_done  = recv_cnt[CNT_W-1];

    // After the last read, the address stays on the last issued word.
    // The word index is IDX_W bits wide, so adding the offset wraps inside the block.
    // That wrap means the block bits [15:4] never receive a carry.
    assign addr_idx   = issue_done ? LAST_IDX : issue_cnt[IDX_W-1:0];
    assign issue_word = addr_idx + word_offset;
    assign recv_word  = recv_cnt[IDX_W-1:0] + word_offset;

    assign memory_address = {base_hi, issue_word, 1'b0};

    // State register.
    // NOTE: sequential state uses non-blocking (<=).
    // With <=, every flop samples pre-edge values no matter how the blocks are ordered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and all strobes.
    // NOTE: every output gets a default before the case statement.
    // A path that leaves an output unassigned would otherwise infer a latch.
    always_comb begin
        state_next       = state;
        accept_miss      = 1'b0;
        fsm_busy         = 1'b0;
        memory_enable    = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (miss_detected) begin
                    accept_miss = 1'b1;
                    state_next  = S_FILL;
                end
            end

            S_FILL: begin
                fsm_busy      = 1'b1;
                memory_enable = !issue_done;
                // Memory returns data in issue order.
                // The receive count alone therefore identifies the word.
                if (memory_data_valid && !recv_done) begin
                    write_data_array = 1'b1;
                    if (recv_cnt == CNT_W'(WORDS - 1)) begin
                        state_next = S_DONE;
                    end
                end
            end

            S_DONE: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                state_next      = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Data-array write port.
    // When no write is in progress it is held at zero.
    // This keeps stray memory_data values off the array inputs.
    assign fill_word = write_data_array ? recv_word   : '0;
    assign fill_data = write_data_array ? memory_data : '0;

    // Latch the block base on an accepted miss.
    // Count issued reads and received words during the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_hi   <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else if (accept_miss) begin
            base_hi   <= miss_address[ADDR_W-1:4];
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            if (memory_enable) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (write_data_array) begin
                recv_cnt <= recv_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: self-checking bench for cache_fill_fsm.
// The memory model is a queue of pending reads; each read returns after a chosen latency.
// Expected addresses, writes, busy window and tag strobe come from the block-fill rules.
// The bench follows CRITICAL_WORD_FIRST_EN the same way the design does.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic [15:0] memory_address;
    logic        memory_enable;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        write_data_array;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        write_tag_array;

    int vectors;
    int miscompares;

    logic [15:0] salt;

    // Pending memory reads: the cycle each one is due, and its byte address.
    int          due_q[$];
    logic [15:0] adr_q[$];

    cache_fill_fsm dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .memory_address    (memory_address),
        .memory_enable     (memory_enable),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .write_data_array  (write_data_array),
        .fill_word         (fill_word),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of memory as seen by the fill.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'(a * 16'h9E37) ^ salt;
    endfunction

    // Fetch order within the block, i.e. the i-th word of a fill for a given miss.
    function automatic int order_of(input logic [15:0] miss, input int i);
`ifdef CRITICAL_WORD_FIRST_EN
        return (int'(miss[3:1]) + i) % 8;
`else
        return i % 8;
`endif
    endfunction

    // Byte address of the i-th read of the fill started by miss.
    function automatic logic [15:0] fill_addr(input logic [15:0] miss, input int i);
        logic [15:0] base;
        base = miss & 16'hFFF0;
        return base + 16'(2 * order_of(miss, i));
    endfunction

    // Runs one fill. Call it mid-cycle, before the edge that should accept the miss.
    // The fill is described in cycles; cycle c ends at accept-edge + c.
    //   - Reads are issued in cycles 1..8.
    //   - The valid for a read arrives lat cycles later.
    //   - DONE is cycle 9+lat; cycle 10+lat is IDLE.
    // hold: keep miss_detected high after acceptance and move miss_address to next_addr.
    // abort_at: cycle in which rst_n is pulsed low (0 = no reset).
    task automatic do_fill(input string name, input logic [15:0] addr, input int lat,
                           input bit hold, input logic [15:0] next_addr, input int abort_at);
        logic        exp_busy, exp_en, exp_wr, exp_tag, aborted;
        logic [2:0]  exp_word;
        logic [15:0] exp_data;
        due_q.delete();
        adr_q.delete();
        miss_detected = 1'b1;
        miss_address  = addr;
        for (int c = 1; c <= 10 + lat; c++) begin
            @(negedge clk);
            if (c == 1) begin
                miss_detected = hold;
                miss_address  = hold ? next_addr : 16'($urandom);
            end
            if (abort_at != 0 && c == abort_at)     rst_n = 1'b0;
            if (abort_at != 0 && c == abort_at + 1) rst_n = 1'b1;
            if (due_q.size() > 0 && due_q[0] == c) begin
                memory_data_valid = 1'b1;
                memory_data       = mem_word(adr_q[0]);
                void'(due_q.pop_front());
                void'(adr_q.pop_front());
            end else if (c >= 9 + lat) begin
                // Stray valid during DONE/IDLE must not write.
                memory_data_valid = 1'b1;
                memory_data       = 16'($urandom);
            end else begin
                memory_data_valid = 1'b0;
                memory_data       = 16'($urandom);
            end
            #1;
            if (memory_enable) begin
                due_q.push_back(c + lat);
                adr_q.push_back(memory_address);
            end

            aborted  = (abort_at != 0 && c >= abort_at);
            exp_busy = !aborted && (c <= 9 + lat);
            exp_en   = !aborted && (c <= 8);
            exp_wr   = !aborted && (c >= 1 + lat) && (c <= 8 + lat);
            exp_tag  = !aborted && (c == 9 + lat);
            exp_word = exp_wr ? 3'(order_of(addr, c - 1 - lat)) : 3'd0;
            exp_data = exp_wr ? mem_word(fill_addr(addr, c - 1 - lat)) : 16'd0;

            vectors++;
            if (fsm_busy !== exp_busy) begin
                miscompares++;
                $display("FAIL %s busy cyc %0d: got %0b want %0b", name, c, fsm_busy, exp_busy);
            end
            vectors++;
            if (memory_enable !== exp_en) begin
                miscompares++;
                $display("FAIL %s enable cyc %0d: got %0b want %0b", name, c, memory_enable, exp_en);
            end
            if (!aborted && c <= 9 + lat) begin
                vectors++;
                if (memory_address !== fill_addr(addr, (c <= 8) ? c - 1 : 7)) begin
                    miscompares++;
                    $display("FAIL %s address cyc %0d: got %h want %h", name, c, memory_address,
                             fill_addr(addr, (c <= 8) ? c - 1 : 7));
                end
            end
            if (abort_at != 0 && c == abort_at) begin
                vectors++;
                if (memory_address !== 16'd0) begin
                    miscompares++;
                    $display("FAIL %s reset address: got %h want 0000", name, memory_address);
                end
            end
            vectors++;
            if (write_data_array !== exp_wr) begin
                miscompares++;
                $display("FAIL %s write cyc %0d: got %0b want %0b", name, c, write_data_array, exp_wr);
            end
            vectors++;
            if (fill_word !== exp_word || fill_data !== exp_data) begin
                miscompares++;
                $display("FAIL %s fill cyc %0d: got word %0d data %h want word %0d data %h",
                         name, c, fill_word, fill_data, exp_word, exp_data);
            end
            vectors++;
            if (write_tag_array !== exp_tag) begin
                miscompares++;
                $display("FAIL %s tag cyc %0d: got %0b want %0b", name, c, write_tag_array, exp_tag);
            end
        end
    endtask

    // Reset state: all outputs 0 while reset is held, even with active inputs.
    task automatic test_reset();
        rst_n             = 1'b0;
        miss_detected     = 1'b1;
        miss_address      = 16'($urandom);
        memory_data_valid = 1'b1;
        memory_data       = 16'($urandom);
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({fsm_busy, memory_enable, write_data_array, write_tag_array} !== 4'b0 ||
            memory_address !== 16'd0 || fill_word !== 3'd0 || fill_data !== 16'd0) begin
            miscompares++;
            $display("FAIL reset outputs: busy %0b en %0b wr %0b tag %0b addr %h word %0d data %h want all 0",
                     fsm_busy, memory_enable, write_data_array, write_tag_array,
                     memory_address, fill_word, fill_data);
        end
        miss_detected = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Valids while idle must never write.
    task automatic test_stray_valid();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            memory_data_valid = 1'b1;
            memory_data       = 16'($urandom);
            #1;
            vectors++;
            if (write_data_array !== 1'b0 || fsm_busy !== 1'b0 || fill_data !== 16'd0) begin
                miscompares++;
                $display("FAIL stray_valid %0d: wr %0b busy %0b data %h want 0 0 0000",
                         i, write_data_array, fsm_busy, fill_data);
            end
        end
        memory_data_valid = 1'b0;
    endtask

    task automatic test_basic();
        do_fill("basic_1236", 16'h1236, 4, 1'b0, 16'h0, 0);
    endtask

    task automatic test_critical_word();
        do_fill("crit_123A", 16'h123A, 3, 1'b0, 16'h0, 0);
    endtask

    task automatic test_top_of_memory();
        do_fill("top_FFFF", 16'hFFFF, 2, 1'b0, 16'h0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            salt = 16'($urandom);
            do_fill("random", 16'($urandom), int'($urandom_range(1, 6)), 1'b0, 16'h0, 0);
        end
    endtask

    // Reset lands in the cycle after the 3rd valid.
    task automatic test_reset_mid_fill();
        do_fill("reset_mid", 16'($urandom), 4, 1'b0, 16'h0, 4 + 4);
    endtask

    // miss_detected stays high throughout. The second fill uses the address present at its
    // accept edge, and is accepted only in the IDLE cycle after DONE.
    task automatic test_back_to_back();
        logic [15:0] a, b;
        a = 16'($urandom);
        b = 16'($urandom);
        do_fill("b2b_first", a, 2, 1'b1, b, 0);
        do_fill("b2b_second", b, 5, 1'b0, 16'h0, 0);
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        salt              = 16'h5A3C;
        rst_n             = 1'b0;
        miss_detected     = 1'b0;
        miss_address      = 16'h0;
        memory_data       = 16'h0;
        memory_data_valid = 1'b0;

        test_reset();
        test_stray_valid();
        test_basic();
        test_critical_word();
        test_top_of_memory();
        test_random();
        test_reset_mid_fill();
        test_stray_valid();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety bound on run time.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
